ifm_stream_tx: RTL and testbench
================================

// Module: ifm_stream_tx
// PURPOSE
//  Source side of the IFM load interface of the fully-connected engine. On start,
//  reads IFM_SIZE words from IFM memory (1-cycle read latency) and drives them on
//  valid_ifm/ifm_data into the FC controller and its IFM buffer write port.
//  A 2-entry prefetch FIFO absorbs memory latency under hold, giving 1 word/cycle.
// PARAMETERS
//  IFM_SIZE  9162  words per frame (>=2)
//  DATA_W    16    IFM word width
//  ADDR_W    16    IFM memory address width
// PORTS
//  clk1         in   1       single clock, all logic on posedge
//  rst          in   1       synchronous reset, active-high
//  start        in   1       begin one frame; sampled only in IDLE
//  base_addr    in   ADDR_W  first word address; latched when start accepted
//  hold         in   1       sink stall: while 1 no word is presented
//  mem_rd_en    out  1       IFM memory read strobe
//  mem_addr     out  ADDR_W  IFM memory read address
//  mem_rd_data  in   DATA_W  read data, valid the cycle after mem_rd_en
//  valid_ifm    out  1       ifm_data holds a word this cycle (one transfer)
//  ifm_data     out  DATA_W  IFM word
//  ifm_last     out  1       with valid_ifm on word IFM_SIZE-1
//  busy         out  1       frame in progress (start accepted, done not yet)
//  done         out  1       1-cycle pulse the cycle after the last transfer
//  word_count   out  16      words transferred in current/last frame
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; mem_rd_en, valid_ifm, ifm_last, busy, done=0;
//   ifm_data, mem_addr, word_count=0; FIFO empty; in-flight read data discarded.
//   Reset mid-frame aborts; no further valid_ifm until next start.
//  FSM: IDLE -start-> FETCH -last read issued-> DRAIN -last word sent-> DONE -> IDLE.
//   IDLE: busy=0; start sampled: latch base_addr, clear rd/tx counters, busy<=1.
//   FETCH: mem_rd_en=1 iff ~hold & (fifo_occ + inflight - pop) < 2; mem_addr =
//    base+rd_cnt (mod 2^ADDR_W); rd_cnt++ per read; after read IFM_SIZE-1 -> DRAIN.
//   DRAIN: no reads; move to DONE on cycle where word IFM_SIZE-1 is transferred.
//   DONE: done=1, busy=0 for exactly one cycle, then IDLE; word_count holds IFM_SIZE.
//  Data path: mem_rd_data written into FIFO the cycle after mem_rd_en. Output reg:
//   valid_ifm <= ~hold & fifo nonempty (pop); ifm_data updates only on pop,
//   otherwise holds last value. hold has one-cycle effect latency on valid_ifm.
//  Latency: start high at cycle N -> mem_rd_en at N+1 (addr=base) -> word 0 with
//   valid_ifm at N+3. hold=0 throughout: IFM_SIZE consecutive valid_ifm cycles,
//   done at N+3+IFM_SIZE.
//  word_count increments per valid_ifm (16-bit, IFM_SIZE <= 65535).
//  FIFO never overflows: issue rule counts in-flight read; pop+push same cycle ok.
//  start while busy or in DONE: ignored, no effect. start and rst together: rst wins.
//  hold asserted whole frame: reads stop at 2 outstanding words, nothing lost;
//   release resumes in order with no duplication or gap in addresses.
// TESTING
//  1 IFM_SIZE=16, base=0x0100, hold=0, mem[a]=a -> mem_rd_en N+1..N+16 addr
//    0x0100..0x010F; valid_ifm N+3..N+18 data 0x0100..0x010F; ifm_last N+18; done N+19.
//  2 hold=1 cycles N+5..N+9 -> at most 2 reads beyond last sent; valid_ifm low
//    N+6..N+10; all 16 words delivered in order exactly once; done after word 15.
//  3 hold toggled every cycle (random seed) -> data sequence == mem order, count 16,
//    FIFO occupancy never >2 (assertion).
//  4 base=0xFFFC, IFM_SIZE=8 -> mem_addr FFFC..FFFF,0000..0003 (wrap).
//  5 start pulsed again at N+7 during frame -> ignored; one frame, one done pulse.
//  6 rst at N+6 mid-frame -> next cycle all outputs 0, no valid_ifm; new start
//    replays full frame from base with word_count restarting at 0.

Source files
------------

// File: rtl/ifm_stream_tx_if.sv
// IFM stream source interface: control, IFM memory read port and IFM word output.
// Ports: start/base_addr/hold in; mem_rd_en/mem_addr out, mem_rd_data in;
//        valid_ifm/ifm_data/ifm_last out; busy/done/word_count status out.
interface ifm_stream_tx_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    // frame control
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              hold;
    // IFM memory read port (1-cycle read latency)
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    // IFM word stream towards the FC controller / IFM buffer
    logic              valid_ifm;
    logic [DATA_W-1:0] ifm_data;
    logic              ifm_last;
    // status
    logic              busy;
    logic              done;
    logic [15:0]       word_count;

    // master: the stream source (ifm_stream_tx)
    modport master (
        input  start, base_addr, hold, mem_rd_data,
        output mem_rd_en, mem_addr, valid_ifm, ifm_data, ifm_last,
               busy, done, word_count
    );

    // slave: controller, memory and sink around the source
    modport slave (
        output start, base_addr, hold, mem_rd_data,
        input  mem_rd_en, mem_addr, valid_ifm, ifm_data, ifm_last,
               busy, done, word_count
    );
endinterface

// File: rtl/ifm_stream_tx.sv
// IFM stream source: reads IFM_SIZE words from IFM memory and streams them out.
// Latency: start at cycle N -> first read N+1 -> first valid_ifm N+3; 1 word/cycle.
// Backpressure: hold stalls the output one cycle later; reads pause with at most
//   two words outstanding (stored + in flight), so nothing is dropped or repeated.
// Ports: clk1 (posedge), rst (sync, active-high), bus (ifm_stream_tx_if.master).
module ifm_stream_tx #(
    parameter int IFM_SIZE = 9162,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16
) (
    input  logic                clk1,
    input  logic                rst,
    ifm_stream_tx_if.master     bus
);

    // index of the final word of a frame, used for both the read and send sides
    localparam logic [15:0] LAST_IDX = 16'(IFM_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // registers
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [ADDR_W-1:0]   r_rd_addr;    // next read address (wraps mod 2^ADDR_W)
    logic [15:0]         r_rd_cnt;     // reads issued this frame
    logic [15:0]         r_tx_cnt;     // words popped this frame (= word_count)
    logic                r_inflight;   // a read was issued last cycle
    logic [1:0]          r_occ;        // prefetch FIFO occupancy (0..2)
    logic [DATA_W-1:0]   r_q0;         // FIFO head
    logic [DATA_W-1:0]   r_q1;         // FIFO second entry
    logic                r_valid;
    logic                r_last;
    logic [DATA_W-1:0]   r_data;

    // ------------------------------------------------------------------
    // combinational signals
    // ------------------------------------------------------------------
    state_t              w_state_nxt;
    logic                w_busy;
    logic                w_avail;
    logic                w_pop;
    logic [DATA_W-1:0]   w_head;
    logic [2:0]          w_pending;
    logic                w_rd_en;
    logic                w_start_acc;
    logic                w_last_rd;
    logic                w_last_tx;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_rd_en     = 1'b0;
        w_start_acc = 1'b0;

        // A word is available when the FIFO holds one or the read issued last
        // cycle is returning now; the returning word can bypass an empty FIFO,
        // which is what makes the N+3 first-word latency possible.
        w_avail   = (r_occ != 2'd0) || r_inflight;
        w_head    = (r_occ != 2'd0) ? r_q0 : bus.mem_rd_data;
        w_pending = {1'b0, r_occ} + {2'b00, r_inflight};

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_busy = 1'b1;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_pop = w_busy && !bus.hold && w_avail;

        // Issue a read only if, after this cycle's pop, fewer than two words
        // would be stored or in flight; this bounds the FIFO at two entries.
        // w_pop implies w_pending >= 1, so the subtraction cannot underflow.
        if (r_state == S_FETCH && !bus.hold &&
            (w_pending - {2'b00, w_pop}) < 3'd2) begin
            w_rd_en = 1'b1;
        end

        w_last_rd = w_rd_en && (r_rd_cnt == LAST_IDX);
        // the last word is "transferred" in the cycle valid_ifm shows it
        w_last_tx = r_valid && r_last;

        if (r_state == S_FETCH && w_last_rd) begin
            w_state_nxt = S_DRAIN;
        end
        if (r_state == S_DRAIN && w_last_tx) begin
            w_state_nxt = S_DONE;
        end
    end

    // ------------------------------------------------------------------
    // state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // read address / frame counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_rd_addr  <= '0;
            r_rd_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_start_acc) begin
                r_rd_addr <= bus.base_addr;
                r_rd_cnt  <= '0;
                r_tx_cnt  <= '0;
            end else begin
                if (w_rd_en) begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                    r_rd_cnt  <= r_rd_cnt + 16'd1;
                end
                if (w_pop) begin
                    r_tx_cnt <= r_tx_cnt + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry prefetch FIFO; the returning read word is the push
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_occ <= 2'd0;
            r_q0  <= '0;
            r_q1  <= '0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10: begin
                    // push only (occupancy is at most 1 here)
                    if (r_occ == 2'd0) begin
                        r_q0 <= bus.mem_rd_data;
                    end else begin
                        r_q1 <= bus.mem_rd_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    // pop only
                    r_q0  <= r_q1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    // push and pop: occupancy 0 is a pure bypass
                    if (r_occ == 2'd1) begin
                        r_q0 <= bus.mem_rd_data;
                    end else if (r_occ == 2'd2) begin
                        r_q0 <= r_q1;
                        r_q1 <= bus.mem_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // output register: data holds its last value when nothing is popped
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_pop;
            r_last  <= w_pop && (r_tx_cnt == LAST_IDX);
            if (w_pop) begin
                r_data <= w_head;
            end
        end
    end

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    assign bus.mem_rd_en  = w_rd_en;
    assign bus.mem_addr   = w_rd_en ? r_rd_addr : '0;
    assign bus.valid_ifm  = r_valid;
    assign bus.ifm_data   = r_data;
    assign bus.ifm_last   = r_last;
    assign bus.busy       = w_busy;
    assign bus.done       = (r_state == S_DONE);
    assign bus.word_count = r_tx_cnt;

endmodule

// File: tb/tb_ifm_stream_tx.sv
// Bench for ifm_stream_tx: cycle-exact vector table for a plain frame, then
// frame runs (hold window, random hold, address wrap, repeated start, reset
// mid-frame) scored against the expected word/address sequences.
module tb_ifm_stream_tx;

    localparam int NW = 16;   // words per frame used by this bench
    localparam int DW = 16;
    localparam int AW = 16;

    logic clk1 = 1'b0;
    logic rst;

    always #5 clk1 = ~clk1;

    ifm_stream_tx_if #(.DATA_W(DW), .ADDR_W(AW)) ifm_if ();

    ifm_stream_tx #(
        .IFM_SIZE (NW),
        .DATA_W   (DW),
        .ADDR_W   (AW)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (ifm_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- IFM memory model: mem[a] = a ^ mem_xor ----------------
    logic [15:0] mem_xor = 16'h0000;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ mem_xor;
    endfunction

    initial begin
        logic        pend_en;
        logic [15:0] pend_addr;
        ifm_if.mem_rd_data = 16'h0000;
        forever begin
            @(negedge clk1);
            pend_en   = ifm_if.mem_rd_en;
            pend_addr = ifm_if.mem_addr;
            @(posedge clk1);
            #1;
            // data appears the cycle after the strobe; junk otherwise
            ifm_if.mem_rd_data = pend_en ? mem_word(pend_addr) : 16'($urandom);
        end
    end

    // ---------------- frame recorder ----------------
    logic [15:0] q_addr[$];
    logic [15:0] q_data[$];
    int          q_vcyc[$];
    int          q_lastcyc[$];
    int          q_donecyc[$];
    int          max_out;
    logic [15:0] done_wc;
    int          valid_after_rst;

    // hold_mode: 0 = never, 1 = cycles 5..9, 2 = random per cycle
    task automatic run_frame(input logic [15:0] base, input int hold_mode,
                             input int start2_at, input int rst_at, input int budget);
        int reads_before = 0;
        int vcount       = 0;
        int done_k       = -1;
        bit finished     = 1'b0;
        q_addr.delete(); q_data.delete(); q_vcyc.delete();
        q_lastcyc.delete(); q_donecyc.delete();
        max_out = 0; done_wc = 16'hDEAD; valid_after_rst = 0;
        for (int k = 0; k < budget && !finished; k++) begin
            @(posedge clk1);
            #1;
            ifm_if.start     = (k == 0) || (k == start2_at);
            ifm_if.base_addr = (k == 0) ? base : 16'($urandom);
            case (hold_mode)
                1:       ifm_if.hold = (k >= 5) && (k <= 9);
                2:       ifm_if.hold = 1'($urandom_range(0, 1));
                default: ifm_if.hold = 1'b0;
            endcase
            rst = (k == rst_at);
            @(negedge clk1);
            if (ifm_if.valid_ifm) begin
                q_data.push_back(ifm_if.ifm_data);
                q_vcyc.push_back(k);
                vcount++;
                if (ifm_if.ifm_last) q_lastcyc.push_back(k);
                if (rst_at >= 0 && k > rst_at) valid_after_rst++;
            end
            // words stored or in flight at this cycle = reads before it minus
            // words already popped (those show as valid by this cycle)
            if (reads_before - vcount > max_out) max_out = reads_before - vcount;
            if (ifm_if.mem_rd_en) begin
                q_addr.push_back(ifm_if.mem_addr);
                reads_before++;
            end
            if (ifm_if.done) begin
                q_donecyc.push_back(k);
                if (done_k < 0) begin
                    done_k  = k;
                    done_wc = ifm_if.word_count;
                end
            end
            if (rst_at >= 0 && k == rst_at + 1) begin
                check("rst_rd_en",  32'(ifm_if.mem_rd_en), 0);
                check("rst_addr",   32'(ifm_if.mem_addr), 0);
                check("rst_valid",  32'(ifm_if.valid_ifm), 0);
                check("rst_data",   32'(ifm_if.ifm_data), 0);
                check("rst_busy",   32'(ifm_if.busy), 0);
                check("rst_wc",     32'(ifm_if.word_count), 0);
            end
            if (rst_at >= 0) finished = (k >= rst_at + 5);
            else             finished = (done_k >= 0) && (k >= done_k + 2);
        end
        ifm_if.start = 1'b0;
        ifm_if.hold  = 1'b0;
        rst          = 1'b0;
        check("frame_end_in_budget", 32'(finished), 1);
    endtask

    task automatic verify_frame(input string nm, input logic [15:0] base);
        int          bad;
        logic [15:0] a;
        check({nm, "_nreads"}, 32'(q_addr.size()), NW);
        bad = 0;
        foreach (q_addr[i]) begin
            a = base + 16'(i);
            if (q_addr[i] !== a) bad++;
        end
        check({nm, "_addr_seq_bad"}, 32'(bad), 0);
        check({nm, "_nwords"}, 32'(q_data.size()), NW);
        bad = 0;
        foreach (q_data[i]) begin
            a = base + 16'(i);
            if (q_data[i] !== mem_word(a)) bad++;
        end
        check({nm, "_data_seq_bad"}, 32'(bad), 0);
        check({nm, "_nlast"}, 32'(q_lastcyc.size()), 1);
        if (q_lastcyc.size() == 1 && q_vcyc.size() == NW)
            check({nm, "_last_on_word15"}, 32'(q_lastcyc[0]), 32'(q_vcyc[NW-1]));
        check({nm, "_ndone"}, 32'(q_donecyc.size()), 1);
        if (q_donecyc.size() == 1 && q_vcyc.size() > 0)
            check({nm, "_done_after_last"}, 32'(q_donecyc[0]), 32'(q_vcyc[q_vcyc.size()-1] + 1));
        check({nm, "_done_wc"}, 32'(done_wc), NW);
        check({nm, "_outstanding_le2"}, 32'(max_out <= 2), 1);
    endtask

    // ---------------- cycle-exact vector table for a plain frame ----------------
    typedef struct {
        logic        start;
        logic        hold;
        logic        exp_rd;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_last;
        logic        exp_busy;
        logic        exp_done;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int exp_v[$];
        int bad;
        ifm_if.start     = 1'b0;
        ifm_if.hold      = 1'b0;
        ifm_if.base_addr = 16'h0000;
        rst              = 1'b1;

        // row k = cycle N+k, start at N, base 0x0100, mem[a] = a
        for (int k = 0; k < 21; k++) begin
            tbl[k].start     = (k == 0);
            tbl[k].hold      = 1'b0;
            tbl[k].exp_rd    = (k >= 1 && k <= 16);
            tbl[k].exp_addr  = tbl[k].exp_rd ? 16'(16'h0100 + k - 1) : 16'h0000;
            tbl[k].exp_valid = (k >= 3 && k <= 18);
            tbl[k].exp_data  = (k < 3) ? 16'h0000 : ((k <= 18) ? 16'(16'h0100 + k - 3) : 16'h010F);
            tbl[k].exp_last  = (k == 18);
            tbl[k].exp_busy  = (k >= 1 && k <= 18);
            tbl[k].exp_done  = (k == 19);
            tbl[k].exp_wc    = (k < 3) ? 16'd0 : ((k - 2 > 16) ? 16'd16 : 16'(k - 2));
        end

        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check("reset_valid", 32'(ifm_if.valid_ifm), 0);
        check("reset_rd_en", 32'(ifm_if.mem_rd_en), 0);
        check("reset_busy",  32'(ifm_if.busy), 0);
        check("reset_done",  32'(ifm_if.done), 0);
        check("reset_data",  32'(ifm_if.ifm_data), 0);
        check("reset_wc",    32'(ifm_if.word_count), 0);
        check("reset_addr",  32'(ifm_if.mem_addr), 0);
        @(posedge clk1);
        #1;
        rst = 1'b0;

        // ---- plain frame, table-driven ----
        mem_xor = 16'h0000;
        foreach (tbl[k]) begin
            @(posedge clk1);
            #1;
            ifm_if.start     = tbl[k].start;
            ifm_if.hold      = tbl[k].hold;
            ifm_if.base_addr = tbl[k].start ? 16'h0100 : 16'h5A5A;
            @(negedge clk1);
            check($sformatf("t1_rd_en[%0d]", k),  32'(ifm_if.mem_rd_en), 32'(tbl[k].exp_rd));
            if (tbl[k].exp_rd)
                check($sformatf("t1_addr[%0d]", k), 32'(ifm_if.mem_addr), 32'(tbl[k].exp_addr));
            check($sformatf("t1_valid[%0d]", k), 32'(ifm_if.valid_ifm), 32'(tbl[k].exp_valid));
            check($sformatf("t1_data[%0d]", k),  32'(ifm_if.ifm_data), 32'(tbl[k].exp_data));
            check($sformatf("t1_last[%0d]", k),  32'(ifm_if.ifm_last), 32'(tbl[k].exp_last));
            check($sformatf("t1_busy[%0d]", k),  32'(ifm_if.busy), 32'(tbl[k].exp_busy));
            check($sformatf("t1_done[%0d]", k),  32'(ifm_if.done), 32'(tbl[k].exp_done));
            check($sformatf("t1_wc[%0d]", k),    32'(ifm_if.word_count), 32'(tbl[k].exp_wc));
        end
        ifm_if.start = 1'b0;

        // ---- hold window N+5..N+9 ----
        mem_xor = 16'h3C00;
        run_frame(16'h0100, 1, -1, -1, 80);
        verify_frame("t2", 16'h0100);
        // one word per cycle except the five stalled cycles, shifted by one
        for (int c = 3; c <= 5; c++)  exp_v.push_back(c);
        for (int c = 11; c <= 23; c++) exp_v.push_back(c);
        bad = 0;
        if (q_vcyc.size() != exp_v.size()) bad = 99;
        else foreach (q_vcyc[i]) if (q_vcyc[i] != exp_v[i]) bad++;
        check("t2_valid_cycles_bad", 32'(bad), 0);

        // ---- random hold, several frames ----
        for (int f = 0; f < 5; f++) begin
            logic [15:0] b;
            b       = 16'($urandom);
            mem_xor = 16'($urandom);
            run_frame(b, 2, -1, -1, 400);
            verify_frame($sformatf("t3_f%0d", f), b);
        end

        // ---- address wrap ----
        mem_xor = 16'h00FF;
        run_frame(16'hFFFC, 0, -1, -1, 80);
        verify_frame("t4", 16'hFFFC);
        if (q_addr.size() > 4) check("t4_wrap_addr4", 32'(q_addr[4]), 0);

        // ---- start again mid-frame, and in the DONE cycle ----
        mem_xor = 16'h1234;
        run_frame(16'h2000, 0, 7, -1, 80);
        verify_frame("t5a", 16'h2000);
        if (q_donecyc.size() > 0) check("t5a_done_cycle", 32'(q_donecyc[0]), 19);
        run_frame(16'h2100, 0, 19, -1, 80);
        verify_frame("t5b", 16'h2100);

        // ---- reset mid-frame, then replay ----
        mem_xor = 16'h0F0F;
        run_frame(16'h0400, 0, -1, 6, 40);
        check("t6_no_valid_after_rst", 32'(valid_after_rst), 0);
        run_frame(16'h0400, 0, -1, -1, 80);
        verify_frame("t6_replay", 16'h0400);
        if (q_vcyc.size() > 0) check("t6_first_valid_cycle", 32'(q_vcyc[0]), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
